// File: rtl/mmul_parallel_tile_sched.sv
// mmul_parallel_tile_sched
//   Tile-level job scheduler sitting between the HWPE control FSM and the
//   streamer. For every tile it issues one address request to each of the
//   in1, in2 and out_r streams, pulses engine_start_o once all three are
//   accepted, then waits for the three stream-done pulses before advancing
//   every base address by its step. Runs cnt_limit_i+1 tiles, then pulses
//   done_o.
//
// Ports
//   clk_i, rst_i (async, active-high), clear_i (sync abort), start_i
//   cnt_limit_i                      tiles minus one, latched at start
//   {in1,in2,out}_base_i/_step_i     first-tile base and per-tile increment
//   {in1,in2,out}_req_o/_addr_o      request valid and tile base address
//   {in1,in2,out}_ready_i            streamer accepts the request
//   {in1,in2,out}_done_i             stream-complete pulse
//   engine_start_o                   1-cycle pulse, first cycle of WAIT
//   tile_idx_o, busy_o, done_o       status
//
// state  | meaning
// IDLE   | waiting for start_i
// ISSUE  | presenting requests for streams not yet accepted
// WAIT   | all requests accepted, collecting stream dones
// FIN    | job complete, done_o high for this cycle
module mmul_parallel_tile_sched #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  cnt_limit_i,
  input  logic [ADDR_W-1:0] in1_base_i,
  input  logic [ADDR_W-1:0] in2_base_i,
  input  logic [ADDR_W-1:0] out_base_i,
  input  logic [ADDR_W-1:0] in1_step_i,
  input  logic [ADDR_W-1:0] in2_step_i,
  input  logic [ADDR_W-1:0] out_step_i,
  output logic              in1_req_o,
  output logic              in2_req_o,
  output logic              out_req_o,
  output logic [ADDR_W-1:0] in1_addr_o,
  output logic [ADDR_W-1:0] in2_addr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  input  logic              in1_ready_i,
  input  logic              in2_ready_i,
  input  logic              out_ready_i,
  input  logic              in1_done_i,
  input  logic              in2_done_i,
  input  logic              out_done_i,
  output logic              engine_start_o,
  output logic [CNT_W-1:0]  tile_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] in1_addr_q, in2_addr_q, out_addr_q;
  logic [ADDR_W-1:0] in1_step_q, in2_step_q, out_step_q;
  logic [CNT_W-1:0]  cnt_lat_q, tile_idx_q;
  // Bit order in the flag vectors: [0]=in1, [1]=in2, [2]=out
  logic [2:0] issued_q, done_q;
  logic [2:0] req, rdy, dn, accept, issued_nxt;
  logic       engine_start_q;
  logic       all_done, last_tile, advance;

  assign rdy        = {out_ready_i, in2_ready_i, in1_ready_i};
  assign dn         = {out_done_i, in2_done_i, in1_done_i};
  assign req        = (state_q == S_ISSUE) ? ~issued_q : 3'b000;
  assign accept     = req & rdy;
  assign issued_nxt = issued_q | accept;
  // Completion is judged on the registered flags, which gives the 3-cycle
  // tile (issue, done, decide) when ready is high and done follows by one.
  assign all_done   = &done_q;
  assign last_tile  = (tile_idx_q == cnt_lat_q);
  assign advance    = (state_q == S_WAIT) && all_done && !last_tile;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        state_q <= S_IDLE;
    else if (clear_i) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_ISSUE;
      S_ISSUE: if (&issued_nxt) state_d = S_WAIT;
      S_WAIT:  if (all_done) state_d = last_tile ? S_FIN : S_ISSUE;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      in1_addr_q     <= '0;
      in2_addr_q     <= '0;
      out_addr_q     <= '0;
      in1_step_q     <= '0;
      in2_step_q     <= '0;
      out_step_q     <= '0;
      cnt_lat_q      <= '0;
      tile_idx_q     <= '0;
      issued_q       <= '0;
      done_q         <= '0;
      engine_start_q <= 1'b0;
    end else begin
      engine_start_q <= (state_q == S_ISSUE) && (&issued_nxt);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            in1_addr_q <= in1_base_i;
            in2_addr_q <= in2_base_i;
            out_addr_q <= out_base_i;
            in1_step_q <= in1_step_i;
            in2_step_q <= in2_step_i;
            out_step_q <= out_step_i;
            cnt_lat_q  <= cnt_limit_i;
            tile_idx_q <= '0;
            issued_q   <= '0;
            done_q     <= '0;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (advance) begin
            in1_addr_q <= in1_addr_q + in1_step_q;
            in2_addr_q <= in2_addr_q + in2_step_q;
            out_addr_q <= out_addr_q + out_step_q;
            tile_idx_q <= tile_idx_q + CNT_W'(1);
            issued_q   <= '0;
            done_q     <= '0;
          end else begin
            issued_q <= issued_nxt;
            // A done for a stream whose request is not yet accepted is
            // dropped; one arriving in its acceptance cycle is kept.
            done_q   <= done_q | (dn & issued_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  assign in1_req_o      = req[0];
  assign in2_req_o      = req[1];
  assign out_req_o      = req[2];
  assign in1_addr_o     = in1_addr_q;
  assign in2_addr_o     = in2_addr_q;
  assign out_addr_o     = out_addr_q;
  assign engine_start_o = engine_start_q;
  assign tile_idx_o     = tile_idx_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_FIN);

endmodule

// File: tb/tb_mmul_parallel_tile_sched.sv
module tb_mmul_parallel_tile_sched;
  localparam int AW = 32;
  localparam int CW = 16;

  logic clk_i = 1'b0, rst_i = 1'b0, clear_i = 1'b0, start_i = 1'b0;
  logic [CW-1:0] cnt_limit_i = '0;
  logic [AW-1:0] in1_base_i = '0, in2_base_i = '0, out_base_i = '0;
  logic [AW-1:0] in1_step_i = '0, in2_step_i = '0, out_step_i = '0;
  logic in1_req_o, in2_req_o, out_req_o;
  logic [AW-1:0] in1_addr_o, in2_addr_o, out_addr_o;
  logic in1_ready_i = 1'b0, in2_ready_i = 1'b0, out_ready_i = 1'b0;
  logic in1_done_i = 1'b0, in2_done_i = 1'b0, out_done_i = 1'b0;
  logic engine_start_o, busy_o, done_o;
  logic [CW-1:0] tile_idx_o;

  mmul_parallel_tile_sched #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .cnt_limit_i(cnt_limit_i),
    .in1_base_i(in1_base_i), .in2_base_i(in2_base_i), .out_base_i(out_base_i),
    .in1_step_i(in1_step_i), .in2_step_i(in2_step_i), .out_step_i(out_step_i),
    .in1_req_o(in1_req_o), .in2_req_o(in2_req_o), .out_req_o(out_req_o),
    .in1_addr_o(in1_addr_o), .in2_addr_o(in2_addr_o), .out_addr_o(out_addr_o),
    .in1_ready_i(in1_ready_i), .in2_ready_i(in2_ready_i), .out_ready_i(out_ready_i),
    .in1_done_i(in1_done_i), .in2_done_i(in2_done_i), .out_done_i(out_done_i),
    .engine_start_o(engine_start_o), .tile_idx_o(tile_idx_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  // streamer responder state; index 0=in1, 1=in2, 2=out
  int pend[3];
  int dly[3];
  logic [2:0] rdy_mask;
  logic go, poke, clr;
  int idx, n_eng, n_done, done_idx;
  int eng_idx[$];
  int in1_acc_idx[$];
  logic [AW-1:0] in1_hist[$];
  logic [AW-1:0] out_hist[$];

  task automatic reset_tb();
    n_eng = 0; n_done = 0; done_idx = -1; idx = 0;
    go = 0; poke = 0; clr = 0; rdy_mask = 3'b111;
    eng_idx.delete(); in1_acc_idx.delete(); in1_hist.delete(); out_hist.delete();
    for (int i = 0; i < 3; i++) begin pend[i] = 0; dly[i] = 1; end
  endtask

  // One cycle: observe at negedge, then drive inputs for the coming posedge.
  task automatic cyc();
    logic [2:0] rq, rd, dn, acc;
    @(negedge clk_i);
    idx++;
    if (engine_start_o) begin n_eng++; eng_idx.push_back(idx); end
    if (done_o) begin n_done++; done_idx = idx; end
    rq = {out_req_o, in2_req_o, in1_req_o};
    start_i = go | poke;
    clear_i = clr;
    if (go) idx = 0;
    go = 0; poke = 0; clr = 0;
    for (int i = 0; i < 3; i++) begin
      dn[i] = (pend[i] == 1);
      if (pend[i] > 0) pend[i]--;
    end
    rd = rdy_mask;
    acc = rq & rd;
    for (int i = 0; i < 3; i++)
      if (acc[i]) begin
        if (dly[i] == 0) dn[i] = 1'b1;
        else pend[i] = dly[i];
      end
    if (acc[0]) begin in1_hist.push_back(in1_addr_o); in1_acc_idx.push_back(idx); end
    if (acc[2]) out_hist.push_back(out_addr_o);
    {out_ready_i, in2_ready_i, in1_ready_i} = rd;
    {out_done_i, in2_done_i, in1_done_i} = dn;
  endtask

  task automatic test_reset();
    reset_tb();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if ({in1_req_o, in2_req_o, out_req_o, engine_start_o, done_o} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {in1_req_o, in2_req_o, out_req_o, engine_start_o, done_o}); end
    checks++; if ({in1_addr_o, in2_addr_o, out_addr_o} !== 96'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", {in1_addr_o, in2_addr_o, out_addr_o}); end
    checks++; if (tile_idx_o !== 16'h0) begin failures++; $display("FAIL reset_tile got=%h exp=0", tile_idx_o); end
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_latency();
    reset_tb();
    cnt_limit_i = 16'd1;
    in1_base_i = 32'h0; in1_step_i = 32'h4;
    go = 1; cyc();
    cyc();
    checks++; if (in1_req_o !== 1'b1) begin failures++; $display("FAIL lat_req got=%b exp=1", in1_req_o); end
    repeat (10) cyc();
    checks++; if (in1_acc_idx.size() < 1 || in1_acc_idx[0] != 1) begin failures++; $display("FAIL lat_accept got=%0d exp=1", in1_acc_idx.size() ? in1_acc_idx[0] : -1); end
    checks++; if (eng_idx.size() < 1 || eng_idx[0] != 2) begin failures++; $display("FAIL lat_engine got=%0d exp=2", eng_idx.size() ? eng_idx[0] : -1); end
    checks++; if (done_idx != 7) begin failures++; $display("FAIL lat_done got=%0d exp=7", done_idx); end
  endtask

  task automatic test_three_tiles();
    reset_tb();
    cnt_limit_i = 16'd2;
    in1_base_i = 32'h100; in1_step_i = 32'h40;
    for (int i = 0; i < 3; i++) dly[i] = 2;
    go = 1; cyc();
    repeat (20) cyc();
    checks++; if (in1_hist.size() != 3) begin failures++; $display("FAIL t1_nreq got=%0d exp=3", in1_hist.size()); end
    checks++; if (in1_hist.size() != 3 || in1_hist[0] !== 32'h100 || in1_hist[1] !== 32'h140 || in1_hist[2] !== 32'h180) begin failures++; $display("FAIL t1_addrs got=%p exp=100,140,180", in1_hist); end
    checks++; if (n_eng != 3) begin failures++; $display("FAIL t1_engine got=%0d exp=3", n_eng); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL t1_done got=%0d exp=1", n_done); end
    checks++; if (tile_idx_o !== 16'd2) begin failures++; $display("FAIL t1_tile got=%0d exp=2", tile_idx_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL t1_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_backpressure();
    reset_tb();
    cnt_limit_i = 16'd0;
    in2_base_i = 32'hABCD_0000;
    rdy_mask = 3'b101;
    go = 1; cyc();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      checks++; if (in2_req_o !== 1'b1 || in2_addr_o !== 32'hABCD_0000) begin failures++; $display("FAIL t2_hold cyc=%0d got=%b/%h exp=1/abcd0000", k, in2_req_o, in2_addr_o); end
      if (k >= 2) begin
        checks++; if ({in1_req_o, out_req_o} !== 2'b00) begin failures++; $display("FAIL t2_others cyc=%0d got=%b exp=00", k, {in1_req_o, out_req_o}); end
      end
    end
    checks++; if (n_eng != 0) begin failures++; $display("FAIL t2_early_engine got=%0d exp=0", n_eng); end
    rdy_mask = 3'b111;
    repeat (8) cyc();
    checks++; if (eng_idx.size() != 1 || eng_idx[0] != 7) begin failures++; $display("FAIL t2_engine got=%0d exp=7", eng_idx.size() ? eng_idx[0] : -1); end
    checks++; if (done_idx != 9 || n_done != 1) begin failures++; $display("FAIL t2_done got=%0d/%0d exp=9/1", done_idx, n_done); end
  endtask

  task automatic test_wrap();
    reset_tb();
    cnt_limit_i = 16'd1;
    out_base_i = 32'hFFFF_FFF0; out_step_i = 32'h20;
    go = 1; cyc();
    repeat (10) cyc();
    checks++; if (out_hist.size() != 2) begin failures++; $display("FAIL t3_nreq got=%0d exp=2", out_hist.size()); end
    checks++; if (out_hist.size() != 2 || out_hist[0] !== 32'hFFFF_FFF0 || out_hist[1] !== 32'h0000_0010) begin failures++; $display("FAIL t3_wrap got=%p exp=fffffff0,00000010", out_hist); end
  endtask

  task automatic test_done_order();
    reset_tb();
    cnt_limit_i = 16'd1;
    dly[0] = 0; dly[1] = 4; dly[2] = 2;
    go = 1; cyc();
    repeat (16) cyc();
    checks++; if (in1_acc_idx.size() != 2 || in1_acc_idx[0] != 1 || in1_acc_idx[1] != 7) begin failures++; $display("FAIL t4_issue got=%p exp=1,7", in1_acc_idx); end
    checks++; if (n_eng != 2) begin failures++; $display("FAIL t4_engine got=%0d exp=2", n_eng); end
    checks++; if (done_idx != 13 || n_done != 1) begin failures++; $display("FAIL t4_done got=%0d/%0d exp=13/1", done_idx, n_done); end
  endtask

  task automatic test_clear();
    reset_tb();
    cnt_limit_i = 16'd2;
    in1_base_i = 32'h100; in1_step_i = 32'h40;
    dly[0] = 6;
    go = 1; cyc();
    repeat (10) cyc();
    checks++; if (tile_idx_o !== 16'd1 || busy_o !== 1'b1 || in1_req_o !== 1'b0) begin failures++; $display("FAIL t5_in_wait got=%0d/%b/%b exp=1/1/0", tile_idx_o, busy_o, in1_req_o); end
    clr = 1; cyc();
    cyc();
    checks++; if ({busy_o, in1_req_o, in2_req_o, out_req_o, engine_start_o, done_o} !== 6'b0) begin failures++; $display("FAIL t5_cleared got=%b exp=000000", {busy_o, in1_req_o, in2_req_o, out_req_o, engine_start_o, done_o}); end
    checks++; if (tile_idx_o !== 16'd0 || in1_addr_o !== 32'h0) begin failures++; $display("FAIL t5_regs got=%0d/%h exp=0/0", tile_idx_o, in1_addr_o); end
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++; if (busy_o !== 1'b0 || n_done != 0) begin failures++; $display("FAIL t5_late_done cyc=%0d got=%b/%0d exp=0/0", k, busy_o, n_done); end
    end
    reset_tb();
    cnt_limit_i = 16'd0;
    go = 1; cyc();
    repeat (6) cyc();
    checks++; if (done_idx != 4 || n_done != 1) begin failures++; $display("FAIL t5_restart got=%0d/%0d exp=4/1", done_idx, n_done); end
    checks++; if (in1_hist.size() != 1 || in1_hist[0] !== 32'h100) begin failures++; $display("FAIL t5_restart_addr got=%p exp=100", in1_hist); end
  endtask

  task automatic test_back_to_back();
    reset_tb();
    cnt_limit_i = 16'd1;
    go = 1; cyc();
    repeat (2) cyc();
    cnt_limit_i = 16'd5;
    poke = 1; cyc();
    repeat (9) cyc();
    checks++; if (done_idx != 7 || n_done != 1) begin failures++; $display("FAIL t6_restart_ignored got=%0d/%0d exp=7/1", done_idx, n_done); end
    checks++; if (n_eng != 2) begin failures++; $display("FAIL t6_engine got=%0d exp=2", n_eng); end
    reset_tb();
    in1_base_i = 32'h200;
    rdy_mask = 3'b000;
    go = 1; cyc();
    repeat (2) cyc();
    checks++; if (in1_req_o !== 1'b1 || in1_addr_o !== 32'h200) begin failures++; $display("FAIL t6_pre_rst got=%b/%h exp=1/200", in1_req_o, in1_addr_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if ({busy_o, in1_req_o, in2_req_o, out_req_o} !== 4'b0 || in1_addr_o !== 32'h0) begin failures++; $display("FAIL t6_async_rst got=%b/%h exp=0000/0", {busy_o, in1_req_o, in2_req_o, out_req_o}, in1_addr_o); end
    rdy_mask = 3'b111;
    cyc();
    rst_i = 1'b0;
    repeat (2) cyc();
    checks++; if (busy_o !== 1'b0 || in1_req_o !== 1'b0 || n_done != 0) begin failures++; $display("FAIL t6_post_rst got=%b/%b/%0d exp=0/0/0", busy_o, in1_req_o, n_done); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_three_tiles();
    test_backpressure();
    test_wrap();
    test_done_order();
    test_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
